// File: rtl/nmos_tr_counter_pkg.sv
// Shared limits for the two-phase toggle-register counter.
package nmos_tr_counter_pkg;

    localparam int unsigned MinWidth = 2;
    localparam int unsigned MaxWidth = 16;

endpackage

// File: rtl/nmos_tr_counter_if.sv
// Phase enables, count/load controls and counter outputs grouped as one bus.
interface nmos_tr_counter_if #(
    parameter int unsigned WIDTH = 9
);

    logic             C1;
    logic             C2;
    logic             EN;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             CO;

    modport master (
        output C1, C2, EN, LD, D,
        input  Q, TC, CO
    );

    modport slave (
        input  C1, C2, EN, LD, D,
        output Q, TC, CO
    );

endinterface

// File: rtl/nmos_trl_cell.sv
// One toggle-register bit: PHI2 evaluates the master, PHI1 copies it to the slave.
module nmos_trl_cell (
    input  logic CLK,
    input  logic R,
    input  logic C1,
    input  logic C2,
    input  logic T,
    input  logic L,
    input  logic D,
    output logic Q
);

    logic m;
    logic s;

    // Both phases sample pre-edge values, so an overlapped edge hands the old master to the slave.
    always_ff @(posedge CLK) begin
        if (C2) begin
            if (R) begin
                m <= 1'b0;
            end else if (L) begin
                m <= D;
            end else begin
                m <= s ^ T;
            end
        end
        if (C1) begin
            s <= m;
        end
    end

    assign Q = s;

endmodule

// File: rtl/nmos_tr_counter.sv
// N-bit two-phase binary counter with AND carry chain, parallel load and terminal-count clear.
module nmos_tr_counter
    import nmos_tr_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned TC_VAL    = 227,
    parameter bit          CLR_ON_TC = 1'b1
) (
    input logic               CLK,
    input logic               R,
    nmos_tr_counter_if.slave  bus
);

    if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_bad_width
        $error("nmos_tr_counter: WIDTH out of range");
    end
    if (TC_VAL >= (32'd1 << WIDTH)) begin : g_bad_tc
        $error("nmos_tr_counter: TC_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] TcVal = TC_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] cell_d;
    logic             tc_hit;
    logic             tc_clr;
    logic             load;

    assign t[0] = bus.EN;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign t[i] = bus.EN & (&q[i-1:0]);
    end

    assign tc_hit = (q == TcVal);
    // The terminal-count clear reuses the load path with an all-zero load value.
    assign tc_clr = CLR_ON_TC & bus.EN & tc_hit;
    assign load   = bus.LD | tc_clr;
    assign cell_d = bus.LD ? bus.D : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        nmos_trl_cell u_cell (
            .CLK (CLK),
            .R   (R),
            .C1  (bus.C1),
            .C2  (bus.C2),
            .T   (t[i]),
            .L   (load),
            .D   (cell_d[i]),
            .Q   (q[i])
        );
    end

    assign bus.Q  = q;
    assign bus.TC = tc_hit;
    assign bus.CO = bus.EN & (&q);

endmodule

// File: tb/tb_nmos_tr_counter.sv
// Three counter configurations driven in lockstep and checked against an arithmetic model.
module tb_nmos_tr_counter;

    logic CLK = 1'b0;
    logic R   = 1'b0;
    always #5 CLK = ~CLK;

    nmos_tr_counter_if #(.WIDTH(9)) bus_a ();
    nmos_tr_counter_if #(.WIDTH(9)) bus_b ();
    nmos_tr_counter_if #(.WIDTH(4)) bus_c ();

    nmos_tr_counter #(.WIDTH(9), .TC_VAL(227), .CLR_ON_TC(1'b1)) u_a (
        .CLK (CLK),
        .R   (R),
        .bus (bus_a)
    );
    nmos_tr_counter #(.WIDTH(9), .TC_VAL(227), .CLR_ON_TC(1'b0)) u_b (
        .CLK (CLK),
        .R   (R),
        .bus (bus_b)
    );
    nmos_tr_counter #(.WIDTH(4), .TC_VAL(9), .CLR_ON_TC(1'b0)) u_c (
        .CLK (CLK),
        .R   (R),
        .bus (bus_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned wid [3] = '{9, 9, 4};
    int unsigned tcv [3] = '{227, 227, 9};
    bit          clr [3] = '{1'b1, 1'b0, 1'b0};

    int unsigned mm [3];
    int unsigned ss [3];
    bit          mk [3] = '{1'b0, 1'b0, 1'b0};
    bit          sk [3] = '{1'b0, 1'b0, 1'b0};
    bit          cur_en;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_q(input int i);
        case (i)
            0:       return 16'(bus_a.Q);
            1:       return 16'(bus_b.Q);
            default: return 16'(bus_c.Q);
        endcase
    endfunction

    function automatic logic obs_tc(input int i);
        case (i)
            0:       return bus_a.TC;
            1:       return bus_b.TC;
            default: return bus_c.TC;
        endcase
    endfunction

    function automatic logic obs_co(input int i);
        case (i)
            0:       return bus_a.CO;
            1:       return bus_b.CO;
            default: return bus_c.CO;
        endcase
    endfunction

    // Apply one clock edge with the given controls, advance the model, then compare all outputs.
    task automatic step(input bit c1, input bit c2, input bit r, input bit en, input bit ld,
                        input int unsigned d, input string tag);
        int unsigned max, dm, nm;
        bit nmk;
        @(negedge CLK);
        R = r;
        cur_en = en;
        bus_a.C1 = c1; bus_a.C2 = c2; bus_a.EN = en; bus_a.LD = ld; bus_a.D = d[8:0];
        bus_b.C1 = c1; bus_b.C2 = c2; bus_b.EN = en; bus_b.LD = ld; bus_b.D = d[8:0];
        bus_c.C1 = c1; bus_c.C2 = c2; bus_c.EN = en; bus_c.LD = ld; bus_c.D = d[3:0];
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            max = (32'd1 << wid[i]) - 1;
            dm  = d & max;
            nm  = mm[i];
            nmk = mk[i];
            if (c2) begin
                if (r) begin
                    nm = 0; nmk = 1'b1;
                end else if (ld) begin
                    nm = dm; nmk = 1'b1;
                end else begin
                    if (en && clr[i] && ss[i] == tcv[i]) nm = 0;
                    else if (en) nm = (ss[i] + 1) % (max + 1);
                    else nm = ss[i];
                    nmk = sk[i];
                end
            end
            if (c1) begin
                ss[i] = mm[i];
                sk[i] = mk[i];
            end
            mm[i] = nm;
            mk[i] = nmk;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            if (sk[i]) begin
                max = (32'd1 << wid[i]) - 1;
                check($sformatf("%s q%0d", tag, i), obs_q(i), 16'(ss[i]));
                check($sformatf("%s tc%0d", tag, i), 16'(obs_tc(i)), 16'(ss[i] == tcv[i]));
                check($sformatf("%s co%0d", tag, i), 16'(obs_co(i)), 16'(cur_en && ss[i] == max));
            end
        end
    endtask

    task automatic pair(input bit r, input bit en, input bit ld, input int unsigned d,
                        input string tag);
        step(1'b0, 1'b1, r, en, ld, d, {tag, " phi2"});
        step(1'b1, 1'b0, 1'b0, en, 1'b0, 0, {tag, " phi1"});
    endtask

    initial begin
        int unsigned sel, d;
        bit c1, c2;
        bit phase;

        // Garbage preload, then reset.
        pair(1'b0, 1'b0, 1'b1, 32'h1AA, "preload");
        pair(1'b1, 1'b0, 1'b0, 0, "reset");
        check("reset q", 16'(bus_a.Q), 16'd0);
        check("reset tc", 16'(bus_a.TC), 16'd0);
        check("reset co", 16'(bus_a.CO), 16'd0);

        for (int k = 0; k < 5; k++) pair(1'b0, 1'b1, 1'b0, 0, "count");
        check("count5", 16'(bus_a.Q), 16'd5);

        // Terminal count, then clear (a) versus continue (b).
        pair(1'b0, 1'b0, 1'b1, 226, "ld226");
        pair(1'b0, 1'b1, 1'b0, 0, "to227");
        check("tc hit q", 16'(bus_a.Q), 16'd227);
        check("tc hit", 16'(bus_a.TC), 16'd1);
        pair(1'b0, 1'b1, 1'b0, 0, "tc clear");
        check("tc clr q", 16'(bus_a.Q), 16'd0);
        check("no clr q", 16'(bus_b.Q), 16'd228);

        // Hold at terminal count.
        pair(1'b0, 1'b0, 1'b1, 227, "ld227");
        pair(1'b0, 1'b0, 1'b0, 0, "hold");
        check("hold tc", 16'(bus_a.TC), 16'd1);

        // Wrap on the 4-bit instance.
        pair(1'b0, 1'b0, 1'b1, 15, "ld15");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "co idle");
        check("wrap co", 16'(bus_c.CO), 16'd1);
        pair(1'b0, 1'b1, 1'b0, 0, "wrap");
        check("wrap q", 16'(bus_c.Q), 16'd0);

        // Priority.
        pair(1'b1, 1'b1, 1'b1, 100, "r_ld_en");
        check("prio r", 16'(bus_a.Q), 16'd0);
        pair(1'b0, 1'b1, 1'b1, 100, "ld_en");
        check("prio ld", 16'(bus_a.Q), 16'd100);

        // R ignored without C2.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, "r no c2");

        // Overlapped phases: M=7, S=3.
        pair(1'b0, 1'b0, 1'b1, 3, "ld3");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7, "ld7 m");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, "overlap");
        check("overlap s", 16'(bus_a.Q), 16'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, "after overlap");
        check("overlap m", 16'(bus_a.Q), 16'd4);

        // Randomized phases and controls.
        phase = 1'b0;
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                c1 = 1'b1; c2 = 1'b1;
            end else if (sel == 1) begin
                c1 = 1'b0; c2 = 1'b0;
            end else begin
                c1 = phase; c2 = ~phase; phase = ~phase;
            end
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(222, 227) : $urandom_range(0, 511);
            step(c1, c2, ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0), d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
